// File: rtl/mod_exp_seq.sv
// mod_exp_seq -- sequential modular exponentiation, result = base^exponent mod modulus.
//
// The exponent is scanned left-to-right (square, then multiply when the bit is set).
// Each modular multiply is a bit-serial interleaved shift-add reduction taking
// exactly WIDTH cycles, so the datapath is one WIDTH+2 bit adder/subtractor chain.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset_n   : synchronous active-low reset
//   start     : request pulse, only looked at in IDLE
//   base      : operand, captured on the accepted start cycle
//   exponent  : operand, captured on the accepted start cycle
//   modulus   : operand, captured on the accepted start cycle
//   busy      : high from the cycle after start acceptance until done
//   done      : 1-cycle pulse, result/error valid
//   result    : base^exponent mod modulus, held until the next accepted start completes
//   error     : modulus==0 or base>=modulus, valid with done and held with result
//
// Parameters
//   WIDTH     : operand width
//   SKIP_LZ   : 1 = leading-zero exponent bits are skipped at 1 cycle each
module mod_exp_seq #(
  parameter int WIDTH   = 256,
  parameter int SKIP_LZ = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = WIDTH + 2;
  localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, SQR, MUL, FIN} state_t;

  state_t state_q, state_d;

  // captured operands
  logic [WIDTH-1:0] b_q, e_q, m_q;
  // acc_q: running exponentiation value; acc2_q: partial product of the current multiply
  logic [WIDTH-1:0] acc_q, acc2_q;
  logic [IW-1:0]    idx_q;   // exponent bit being processed
  logic [IW-1:0]    cnt_q;   // multiplier bit being processed (MSB first)

  // control decodes
  logic             op_err;
  logic             ebit;
  logic [IW-1:0]    idx_dec;
  logic             ebit_next;
  logic             mm_last;
  logic             mm_bit;
  logic [WIDTH-1:0] mm_cand;
  logic             close_bit;

  // shift-add step
  logic [DW-1:0]    m_ext, t_shift, t_red1, t_add;
  logic [WIDTH-1:0] mm_next;

  // ---------------------------------------------------------------------------
  // state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // output / decode combinational process
  // ---------------------------------------------------------------------------
  always_comb begin
    op_err    = (m_q == '0) || (b_q >= m_q);
    ebit      = e_q[idx_q];
    idx_dec   = idx_q - IW'(1);
    ebit_next = e_q[idx_dec];
    mm_last   = (cnt_q == '0);
    // SQR multiplies acc by itself, MUL multiplies acc by base; acc is always the
    // scanned multiplier and stays untouched until the last step of the multiply.
    mm_bit    = acc_q[cnt_q];
    mm_cand   = (state_q == MUL) ? b_q : acc_q;
    // a bit is finished after MUL, or after SQR when no multiply is needed
    close_bit = (state_q == MUL) || ((state_q == SQR) && !ebit);

    // acc2 < m, so 2*acc2 < 2m and (acc2 mod m) + cand < 2m: one conditional
    // subtract after each half-step keeps the value fully reduced in WIDTH+2 bits.
    m_ext   = {2'b00, m_q};
    t_shift = {1'b0, acc2_q, 1'b0};
    t_red1  = (t_shift >= m_ext) ? (t_shift - m_ext) : t_shift;
    t_add   = mm_bit ? (t_red1 + {2'b00, mm_cand}) : t_red1;
    mm_next = WIDTH'((t_add >= m_ext) ? (t_add - m_ext) : t_add);
  end

  // ---------------------------------------------------------------------------
  // next-state combinational process
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (op_err)
          state_d = FIN;
        // Leading zeros are skipped by SCAN; a set MSB goes straight to SQR so
        // the scan costs exactly one cycle per leading zero.
        else if ((SKIP_LZ != 0) && !e_q[WIDTH-1])
          state_d = SCAN;
        else
          state_d = SQR;
      end
      SCAN: begin
        // Reaching bit 0 here means every exponent bit was zero.
        if (idx_q == '0)    state_d = FIN;
        else if (ebit_next) state_d = SQR;
      end
      SQR: begin
        if (mm_last) begin
          if (ebit)                state_d = MUL;
          else if (idx_q == '0)    state_d = FIN;
        end
      end
      MUL: begin
        if (mm_last && (idx_q == '0)) state_d = FIN;
        else if (mm_last)             state_d = SQR;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      b_q    <= '0;
      e_q    <= '0;
      m_q    <= '0;
      acc_q  <= '0;
      acc2_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            b_q   <= base;
            e_q   <= exponent;
            m_q   <= modulus;
            error <= 1'b0;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          idx_q  <= TOP;
          cnt_q  <= TOP;
          acc2_q <= '0;
          if (op_err) begin
            error <= 1'b1;
            acc_q <= '0;
          end else begin
            acc_q <= (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
          end
        end
        SCAN: begin
          if (idx_q != '0) idx_q <= idx_dec;
        end
        SQR, MUL: begin
          if (!mm_last) begin
            acc2_q <= mm_next;
            cnt_q  <= cnt_q - IW'(1);
          end else begin
            acc_q  <= mm_next;
            acc2_q <= '0;
            cnt_q  <= TOP;
            if (close_bit && (idx_q != '0)) idx_q <= idx_dec;
          end
        end
        FIN: begin
          result <= acc_q;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_seq.sv
// Scoreboard bench for mod_exp_seq (WIDTH=16): one instance per SKIP_LZ setting,
// shared operands and reset, expected result/error/latency pushed per request.
module tb_mod_exp_seq;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           t0;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start0, start1;
  logic [W-1:0] base, exponent, modulus;
  logic         busy0, done0, error0, busy1, done1, error1;
  logic [W-1:0] result0, result1;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_exp_seq #(.WIDTH(W), .SKIP_LZ(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0),
    .base(base), .exponent(exponent), .modulus(modulus),
    .busy(busy0), .done(done0), .result(result0), .error(error0)
  );

  mod_exp_seq #(.WIDTH(W), .SKIP_LZ(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .base(base), .exponent(exponent), .modulus(modulus),
    .busy(busy1), .done(done1), .result(result1), .error(error1)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic score(input int sel, input logic [W-1:0] r, input logic e);
    exp_t x;
    if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done dut%0d at cycle %0d", sel, cyc);
    end else begin
      x = (sel == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("dut%0d result", sel), r, x.res);
      chk($sformatf("dut%0d error", sel), e, x.err);
      chk($sformatf("dut%0d latency", sel), cyc - x.t0, x.lat);
    end
  endtask

  // Issue one request and wait for it to finish. glitch>0 pulses start again
  // that many cycles in and scrambles the operand inputs mid-operation.
  task automatic run_op(input int sel, input logic [W-1:0] b, input logic [W-1:0] e,
                        input logic [W-1:0] m, input logic [W-1:0] r, input logic er,
                        input int lat, input int glitch);
    exp_t x;
    int n;
    @(negedge clk);
    base = b; exponent = e; modulus = m;
    x.res = r; x.err = er; x.lat = lat; x.t0 = cyc + 1;
    if (sel == 0) begin start0 = 1'b1; q0.push_back(x); end
    else          begin start1 = 1'b1; q1.push_back(x); end
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    n = 1;
    while (((sel == 0) ? busy0 : busy1) && n < 5000) begin
      if (glitch > 0 && n == glitch) begin
        base = 16'h1234; exponent = 16'hFFFF; modulus = 16'h0007;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start0 = 1'b0; start1 = 1'b0;
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d waiting for done", sel);
    end
    @(negedge clk);
  endtask

  initial begin
    bit saw_done;
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    base = '0; exponent = '0; modulus = '0;

    fork
      forever begin
        @(negedge clk);
        if (reset_n) begin
          if (done0) score(0, result0, error0);
          if (done1) score(1, result1, error1);
        end
      end
    join_none

    // start while in reset must be ignored
    repeat (2) @(negedge clk);
    start0 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    chk("reset busy0", busy0, 0);
    chk("reset done0", done0, 0);
    chk("reset result0", result0, 0);
    chk("reset error0", error0, 0);
    chk("reset busy1", busy1, 0);
    chk("reset done1", done1, 0);
    chk("reset result1", result1, 0);
    chk("reset error1", error1, 0);
    reset_n = 1'b1;
    @(negedge clk);

    //     sel  base      exp       mod       result    err  latency
    run_op(0,  16'd4,    16'd13,   16'd497,  16'd445,  0,   306, 0);
    run_op(1,  16'd4,    16'd13,   16'd497,  16'd445,  0,   126, 0);
    run_op(0,  16'd65,   16'd17,   16'd3233, 16'd2790, 0,   290, 0);
    run_op(0,  16'd2790, 16'd2753, 16'd3233, 16'd65,   0,   338, 0);
    run_op(1,  16'd2790, 16'd2753, 16'd3233, 16'd65,   0,   278, 0);
    run_op(0,  16'd7,    16'd0,    16'd11,   16'd1,    0,   258, 0);
    run_op(1,  16'd7,    16'd0,    16'd11,   16'd1,    0,   18,  0);
    run_op(0,  16'd0,    16'd0,    16'd1,    16'd0,    0,   258, 0);
    run_op(1,  16'd0,    16'd5,    16'd1,    16'd0,    0,   95,  0);
    run_op(0,  16'd3,    16'd5,    16'd0,    16'd0,    1,   2,   0);
    run_op(1,  16'd20,   16'd5,    16'd11,   16'd0,    1,   2,   0);
    run_op(1,  16'd1,    16'hFFFF, 16'd7,    16'd1,    0,   514, 0);
    run_op(1,  16'd0,    16'h8000, 16'd5,    16'd0,    0,   274, 0);
    run_op(0,  16'd65534,16'd3,    16'd65535,16'd65534,0,   290, 0);
    run_op(0,  16'd2,    16'd16,   16'd65535,16'd1,    0,   274, 0);

    // reset pulse mid-SQR: operation aborts silently
    @(negedge clk);
    base = 16'd4; exponent = 16'd13; modulus = 16'd497;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midreset busy0", busy0, 0);
    chk("midreset done0", done0, 0);
    chk("midreset result0", result0, 0);
    saw_done = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (done0) saw_done = 1'b1;
    end
    chk("midreset no done", saw_done, 0);

    // fresh start after the abort, then a start pulse while busy
    run_op(0,  16'd4,    16'd13,   16'd497,  16'd445,  0,   306, 0);
    run_op(0,  16'd65,   16'd17,   16'd3233, 16'd2790, 0,   290, 40);
    run_op(1,  16'd4,    16'd13,   16'd497,  16'd445,  0,   126, 20);

    repeat (5) @(negedge clk);
    chk("queue0 drained", q0.size(), 0);
    chk("queue1 drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
